dmem_responder: RTL

Data-memory responder on the far side of the pipeline's MEM-stage memory interface. It accepts word loads and stores issued by the datapath from ALUResultM, WriteDataM and MemWriteM, and returns ReadDataM. It models a configurable-latency memory with an internal word array. It raises MemStallM to the hazard unit while an access is in flight, so the pipeline freezes until the response cycle.

---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 89 ++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory bus between the pipeline datapath and the responder.
interface dmem_responder_if #(
    parameter int WIDTH = 32
);
    logic             MemReadM;
    logic             MemWriteM;
    logic [WIDTH-1:0] ALUResultM;
    logic [WIDTH-1:0] WriteDataM;
    logic [WIDTH-1:0] ReadDataM;
    logic             MemStallM;
    logic             MemErrM;
    logic             MemDoneM;

    modport master (
        output MemReadM, MemWriteM, ALUResultM, WriteDataM,
        input  ReadDataM, MemStallM, MemErrM, MemDoneM
    );

    modport slave (
        input  MemReadM, MemWriteM, ALUResultM, WriteDataM,
        output ReadDataM, MemStallM, MemErrM, MemDoneM
    );
endinterface

// File: rtl/dmem_responder.sv
// Configurable-latency word memory behind the MEM stage. Each access is
// accepted in IDLE, waits LATENCY cycles in WAIT, and completes in RESP.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2,
    parameter int WIDTH   = 32
) (
    input logic            clk,
    input logic            reset,
    dmem_responder_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int               IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-3:0] depthLim = (WIDTH-2)'(DEPTH);
    localparam logic [3:0]       latInit  = 4'(LATENCY);

    generate
        if (LATENCY < 0 || LATENCY > 15) begin : gLatencyCheck
            $error("dmem_responder: LATENCY must be within 0..15");
        end
    endgenerate

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             we;
    logic             re;
    logic [WIDTH-1:0] mem [DEPTH];

    logic            req;
    logic            err;
    logic [IDXW-1:0] idx;

    assign req = bus.MemReadM | bus.MemWriteM;
    assign err = (addr[1:0] != 2'b00) || (addr[WIDTH-1:2] >= depthLim);
    assign idx = addr[IDXW+1:2];

    // Access sequencer: latch the request in IDLE, count wait states, respond.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
            wdata <= '0;
            we    <= 1'b0;
            re    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr  <= bus.ALUResultM;
                        wdata <= bus.WriteDataM;
                        we    <= bus.MemWriteM;
                        re    <= bus.MemReadM;
                        cnt   <= latInit;
                        state <= (LATENCY > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Store commit at the end of RESP; a coincident reset drops the store.
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && we && !err) begin
            mem[idx] <= wdata;
        end
    end

    // Handshake outputs; a combined load+store behaves as a store, so no read data.
    always_comb begin
        bus.MemStallM = (state == IDLE && req) || (state == WAIT);
        bus.MemDoneM  = (state == RESP);
        bus.MemErrM   = (state == RESP) && err;
        bus.ReadDataM = (state == RESP && re && !we && !err) ? mem[idx] : '0;
    end
endmodule
